alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port run  input  1  permits command issue when high.
REQ-005 SHALL have port acc_clr  input  1  synchronous accumulator clear request.
REQ-006 SHALL have port in_valid  input  1  command present.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept.
REQ-008 SHALL have port in_op  input  3  ALU function code.
REQ-009 SHALL have port in_a  input  8  operand A.
REQ-010 SHALL have port acc  output  8  accumulator (operand B, result).
REQ-011 SHALL have port done  output  1  one-cycle pulse per completed command.
REQ-012 SHALL have port busy  output  1  high when state is not IDLE.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-014 SHALL compute f from A and B=acc, mod 256: 000 ~A|B; 001 ~A|~B; 010 ~A; 011 A&B; 100 A+B; 101 ~A&~B; 110 popcount(A); 111 popcount(A)+popcount(B).
REQ-015 SHALL push {in_op,in_a} on an edge with in_valid & in_ready; in_ready = (level != DEPTH).
REQ-016 SHALL ignore in_valid while full, with no FIFO or level change.
REQ-017 SHALL, on simultaneous push and pop, perform both, leaving level unchanged; FIFO pointers wrap modulo DEPTH.
REQ-018 SHALL have FSM states IDLE, EXEC, WB.
REQ-019 IDLE->EXEC when run & level!=0: pop head into op/A registers; otherwise remain IDLE.
REQ-020 EXEC->WB unconditionally: register f into result register.
REQ-021 WB: write result to acc, assert done for the following cycle; ->EXEC with a pop if run & level!=0, else ->IDLE.
REQ-022 Latency SHALL be: command pushed at edge N into an empty FIFO while IDLE and run=1 -> popped at N+1, acc updated and done high after edge N+3; back-to-back commands complete every 2 cycles.
REQ-023 run low SHALL only block new pops; a command already in EXEC/WB SHALL complete.
REQ-024 acc_clr SHALL set acc to 0x00 at the next edge and take priority over a WB write in the same cycle; done still pulses; FIFO and FSM unaffected.
REQ-025 B for op 000/001/011/100/101/111 SHALL be acc as sampled in EXEC (after any prior WB).

Reset
REQ-026 reset_n low SHALL asynchronously force state IDLE, acc 0x00, done 0, busy 0, level 0, FIFO pointers 0, op/A/result registers 0.
REQ-027 Reset mid-operation SHALL discard in-flight and queued commands; no done pulse follows.
REQ-028 Deassertion SHALL take effect at the first clk edge with reset_n high; in_ready is 1 that cycle.

Structure
REQ-029 Opcode constants (8 function codes) and FSM state encoding SHALL live in shared package alu_seq_pkg.
REQ-030 Combinational function of REQ-014 SHALL be a sub-module alu8 (inputs a, b, op; output f); FIFO inline.

Verification
REQ-031 Reset, then release -> acc=0x00, level=0, in_ready=1, busy=0, done=0.
REQ-032 run=1, push op 100 A=0x05 twice back-to-back -> acc 0x05 then 0x0A, done pulses 2 cycles apart, level returns to 0.
REQ-033 acc=0xF0, push op 100 A=0x20 -> acc 0x10 (wrap); then op 111 A=0xFF -> acc 0x09 (8+1).
REQ-034 run=0, push 5 commands -> level=4, in_ready=0 after 4th, 5th ignored; raise run -> exactly 4 done pulses.
REQ-035 acc_clr asserted in WB cycle of op 010 A=0x0F -> acc 0x00, done pulses once.
REQ-036 reset_n low during EXEC with 2 queued -> immediately idle/empty, no done after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- definitions shared by the ALU sequencer and its datapath.
//   alu_op_e  : the eight 3-bit ALU function codes
//   state_e   : sequencer FSM state encoding (IDLE, EXEC, WB)
//   popcount8 : number of set bits in an 8-bit value
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int CMD_W  = OP_W + DATA_W;

  typedef enum logic [OP_W-1:0] {
    OP_NOTA_OR_B = 3'b000,  // ~A | B
    OP_NAND      = 3'b001,  // ~A | ~B
    OP_NOTA      = 3'b010,  // ~A
    OP_AND       = 3'b011,  // A & B
    OP_ADD       = 3'b100,  // A + B (mod 256)
    OP_NOR       = 3'b101,  // ~A & ~B
    OP_POPA      = 3'b110,  // popcount(A)
    OP_POPAB     = 3'b111   // popcount(A) + popcount(B)
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  function automatic logic [3:0] popcount8(input logic [DATA_W-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < DATA_W; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/alu8.sv
// alu8 -- purely combinational 8-bit ALU.
//   a  : operand A
//   b  : operand B (the accumulator in the sequencer)
//   op : function code (alu_op_e)
//   f  : result, modulo 256
module alu8
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] f
);

  logic [3:0] pop_a;
  logic [3:0] pop_b;

  assign pop_a = popcount8(a);
  assign pop_b = popcount8(b);

  always_comb begin
    f = '0;
    case (op)
      OP_NOTA_OR_B: f = ~a | b;
      OP_NAND:      f = ~a | ~b;
      OP_NOTA:      f = ~a;
      OP_AND:       f = a & b;
      OP_ADD:       f = a + b;
      OP_NOR:       f = ~a & ~b;
      OP_POPA:      f = {4'h0, pop_a};
      OP_POPAB:     f = {4'h0, pop_a} + {4'h0, pop_b};
      default:      f = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer -- queues {op, A} commands in a small FIFO and executes them
// one at a time against an 8-bit accumulator (acc = f(A, acc)).
//   clk, reset_n : clock (rising edge) and asynchronous active-low reset
//   run          : allows the FSM to pop new commands
//   acc_clr      : clears acc at the next edge, overriding a write-back
//   in_valid/in_ready, in_op, in_a : command push interface
//   acc          : accumulator value
//   done         : one-cycle pulse after each command's write-back
//   busy         : FSM not in IDLE
//   level        : FIFO occupancy (0..DEPTH)
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     run,
  input  logic                     acc_clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_op,
  input  logic [DATA_W-1:0]        in_a,
  output logic [DATA_W-1:0]        acc,
  output logic                     done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // FIFO storage and bookkeeping
  logic [CMD_W-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push;
  logic             pop;
  logic [CMD_W-1:0] head;

  // Sequencer registers
  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic             done_q, done_d;
  logic [DATA_W-1:0] alu_f;

  assign in_ready = (level_q != LW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign head     = fifo_mem[rd_ptr_q];

  // Storage has no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {in_op, in_a};
    end
  end

  alu8 u_alu8 (
    .a  (a_q),
    .b  (acc_q),
    .op (op_q),
    .f  (alu_f)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    result_d = result_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run && (level_q != '0)) begin
          pop     = 1'b1;
          op_d    = head[CMD_W-1:DATA_W];
          a_d     = head[DATA_W-1:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // acc already holds any previous write-back, so B is current here.
        result_d = alu_f;
        state_d  = ST_WB;
      end
      ST_WB: begin
        acc_d  = result_q;
        done_d = 1'b1;
        if (run && (level_q != '0)) begin
          pop     = 1'b1;
          op_d    = head[CMD_W-1:DATA_W];
          a_d     = head[DATA_W-1:0];
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear wins over write-back; done is still reported.
    if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      result_q <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign acc   = acc_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);
  assign level = level_q;

endmodule
